wb_stage: RTL

//  MEM/WB pipeline register plus write-back datapath of the 5-stage RV32I core.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_load_ext.sv | 24 ++
 rtl/wb_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and encodings for the MEM/WB write-back stage
package wb_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int RA_W_DEF  = 5;
  localparam int CNT_W_DEF = 64;
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: extracts and extends a byte/half/word from an aligned load word
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // Halves use off[1] only, so a misaligned half silently picks its containing half
  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    value  = funct3 == F3_LB  ? {{(XLEN-8){byte_v[7]}}, byte_v} :
             funct3 == F3_LH  ? {{(XLEN-16){half_v[15]}}, half_v} :
             funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, byte_v} :
             funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, half_v} :
             rdata;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, write-back mux, RF write/bypass port and retire counter
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_alu,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  mem_imm,
  input  logic [2:0]       mem_funct3,
  input  logic [1:0]       mem_wb_sel,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_rf_we,
  output logic [RA_W-1:0]  rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             rf_we,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_wd,
  output logic             fwd_we,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_pc,
  output logic [CNT_W-1:0] instret
);
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             rf_we_q, rf_we_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  wd;
  logic             we;

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata  (rdata_q),
    .off    (alu_q[1:0]),
    .funct3 (funct3_q),
    .value  (load_val)
  );

  // MEM/WB next state: flush zeroes the register (bubble), stall holds it, else capture MEM
  always_comb begin
    valid_d  = flush ? 1'b0 : stall ? valid_q  : mem_valid;
    pc_d     = flush ? '0   : stall ? pc_q     : mem_pc;
    alu_d    = flush ? '0   : stall ? alu_q    : mem_alu;
    rdata_d  = flush ? '0   : stall ? rdata_q  : mem_rdata;
    imm_d    = flush ? '0   : stall ? imm_q    : mem_imm;
    funct3_d = flush ? '0   : stall ? funct3_q : mem_funct3;
    wb_sel_d = flush ? '0   : stall ? wb_sel_q : mem_wb_sel;
    rd_d     = flush ? '0   : stall ? rd_q     : mem_rd;
    rf_we_d  = flush ? 1'b0 : stall ? rf_we_q  : mem_rf_we;
  end

  // Write-back value and enable come only from latched fields; x0 never gets a write
  always_comb begin
    wd = wb_sel_q == WB_SEL_ALU  ? alu_q :
         wb_sel_q == WB_SEL_LOAD ? load_val :
         wb_sel_q == WB_SEL_PC4  ? pc_q + XLEN'(4) :
         imm_q;
    we = valid_q & rf_we_q & (rd_q != '0);
  end

  // RF port and bypass tap are the same write; retire only when not held by a stall
  always_comb begin
    rf_wa     = rd_q;
    rf_wd     = wd;
    rf_we     = we;
    fwd_rd    = rd_q;
    fwd_wd    = wd;
    fwd_we    = we;
    wb_valid  = valid_q & ~stall;
    wb_pc     = valid_q ? pc_q : '0;
    instret   = instret_q;
    instret_d = instret_q + CNT_W'(valid_q & ~stall);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      rdata_q   <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      wb_sel_q  <= '0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      rdata_q   <= rdata_d;
      imm_q     <= imm_d;
      funct3_q  <= funct3_d;
      wb_sel_q  <= wb_sel_d;
      rd_q      <= rd_d;
      rf_we_q   <= rf_we_d;
      instret_q <= instret_d;
    end
  end
endmodule
